multicycle_ctrl: RTL and testbench

//  Multi-cycle RV32I control FSM. Drives the write enables of the state registers (instr_reg,

---
 rtl/multicycle_ctrl_pkg.sv | 58 +++++
 rtl/multicycle_ctrl_branch_cond.sv | 25 ++
 rtl/multicycle_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, opcodes, mux selects, ALU ops.
// The TRAP state exists only when ILLEGAL_TRAP_EN is defined.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECR     = 4'd6,
        S_EXECI     = 4'd7,
        S_ALUWB     = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_LINK = 4'd11,
        S_JALR_JMP  = 4'd12
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP    = 4'd13
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] A_PC     = 2'd0;
    localparam logic [1:0] A_OLD_PC = 2'd1;
    localparam logic [1:0] A_RD1    = 2'd2;
    localparam logic [1:0] A_ZERO   = 2'd3;

    localparam logic [1:0] B_RD2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [1:0] RS_ALU_REG    = 2'd0;
    localparam logic [1:0] RS_DATA_REG   = 2'd1;
    localparam logic [1:0] RS_ALU_RESULT = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch resolution: maps funct3 and the ALU compare flags of rs1-rs2 to taken.
module branch_cond
    import multicycle_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM (Moore outputs gated by mem_ready and branch outcome).
// Optional ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP and raise illegal_instr.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int SEL_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               zero,
    input  logic               lt,
    input  logic               ltu,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               data_en,
    output logic               rd_en,
    output logic               alu_en,
    output logic               reg_write,
    output logic [SEL_W-1:0]   alu_src_a,
    output logic [SEL_W-1:0]   alu_src_b,
    output logic [SEL_W-1:0]   result_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         state_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic               illegal_instr
`endif
);

    state_t     state, next;
    logic       taken;
    logic [1:0] a_sel, b_sel, rs_sel, op_sel;
    logic       trap;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next;
    end

    // Everything is forced low while rst is high so an interrupted store never issues.
    always_comb begin
        next      = state;
        pc_write  = 1'b0;
        adr_src   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        data_en   = 1'b0;
        rd_en     = 1'b0;
        alu_en    = 1'b0;
        reg_write = 1'b0;
        a_sel     = A_PC;
        b_sel     = B_RD2;
        rs_sel    = RS_ALU_REG;
        op_sel    = ALU_ADD;
        trap      = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    a_sel    = A_PC;
                    b_sel    = B_FOUR;
                    rs_sel   = RS_ALU_RESULT;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                    if (mem_ready) next = S_DECODE;
                end
                S_DECODE: begin
                    rd_en  = 1'b1;
                    alu_en = 1'b1;
                    a_sel  = A_OLD_PC;
                    b_sel  = B_IMM;
                    case (opcode)
                        OP_LOAD, OP_STORE:          next = S_MEMADR;
                        OP_OP:                      next = S_EXECR;
                        OP_OPIMM, OP_LUI, OP_AUIPC: next = S_EXECI;
                        OP_BRANCH:                  next = S_BRANCH;
                        OP_JAL:                     next = S_JAL;
                        OP_JALR:                    next = S_JALR_LINK;
`ifdef ILLEGAL_TRAP_EN
                        default:                    next = S_TRAP;
`else
                        default:                    next = S_FETCH;
`endif
                    endcase
                end
                S_MEMADR: begin
                    a_sel  = A_RD1;
                    b_sel  = B_IMM;
                    alu_en = 1'b1;
                    next   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    adr_src  = 1'b1;
                    mem_read = 1'b1;
                    data_en  = mem_ready;
                    if (mem_ready) next = S_MEMWB;
                end
                S_MEMWB: begin
                    rs_sel    = RS_DATA_REG;
                    reg_write = 1'b1;
                    next      = S_FETCH;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) next = S_FETCH;
                end
                S_EXECR: begin
                    a_sel  = A_RD1;
                    b_sel  = B_RD2;
                    op_sel = ALU_FUNCT;
                    alu_en = 1'b1;
                    next   = S_ALUWB;
                end
                S_EXECI: begin
                    b_sel  = B_IMM;
                    alu_en = 1'b1;
                    if (opcode == OP_LUI) begin
                        a_sel = A_ZERO;
                    end else if (opcode == OP_AUIPC) begin
                        a_sel = A_OLD_PC;
                    end else begin
                        a_sel  = A_RD1;
                        op_sel = ALU_FUNCT;
                    end
                    next = S_ALUWB;
                end
                S_ALUWB: begin
                    rs_sel    = RS_ALU_REG;
                    reg_write = 1'b1;
                    next      = S_FETCH;
                end
                S_BRANCH: begin
                    a_sel    = A_RD1;
                    b_sel    = B_RD2;
                    op_sel   = ALU_SUB;
                    rs_sel   = RS_ALU_REG;
                    pc_write = taken;
                    next     = S_FETCH;
                end
                S_JAL: begin
                    rs_sel   = RS_ALU_REG;
                    pc_write = 1'b1;
                    a_sel    = A_OLD_PC;
                    b_sel    = B_FOUR;
                    alu_en   = 1'b1;
                    next     = S_ALUWB;
                end
                S_JALR_LINK: begin
                    a_sel     = A_OLD_PC;
                    b_sel     = B_FOUR;
                    rs_sel    = RS_ALU_RESULT;
                    reg_write = 1'b1;
                    next      = S_JALR_JMP;
                end
                S_JALR_JMP: begin
                    a_sel    = A_RD1;
                    b_sel    = B_IMM;
                    rs_sel   = RS_ALU_RESULT;
                    pc_write = 1'b1;
                    next     = S_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: begin
                    trap = 1'b1;
                    next = S_TRAP;
                end
`endif
                default: next = S_FETCH;
            endcase
        end
    end

    assign alu_src_a  = SEL_W'(a_sel);
    assign alu_src_b  = SEL_W'(b_sel);
    assign result_src = SEL_W'(rs_sel);
    assign alu_op     = ALUOP_W'(op_sel);
    assign state_o    = rst ? 4'd0 : state;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = trap;
`else
    logic unused_trap;
    assign unused_trap = trap;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors, negedge monitor.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_read, mem_write, ir_write, data_en, rd_en, alu_en, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic [3:0] state_o;
    logic       ill_act;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [21:0] exp_q[$];
    string       name_q[$];

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPIMM = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, BR = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BAD = 7'h7F;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ALUOP_W(2), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .data_en(data_en), .rd_en(rd_en), .alu_en(alu_en),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_op(alu_op), .state_o(state_o)
`ifdef ILLEGAL_TRAP_EN
        , .illegal_instr(ill_act)
`endif
    );
`ifndef ILLEGAL_TRAP_EN
    assign ill_act = 1'b0;
`endif

    // en = {pc_write, adr_src, mem_read, mem_write, ir_write, data_en, rd_en, alu_en, reg_write}
    function automatic logic [21:0] v(input logic [3:0] st, input logic [8:0] en,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] rs, input logic [1:0] op,
                                      input logic ill);
        return {ill, st, en, a, b, rs, op};
    endfunction

    task automatic step(input string nm, input logic r, input logic [6:0] opc,
                        input logic [2:0] f3, input logic z, input logic l, input logic lu,
                        input logic mr, input logic [21:0] e);
        @(posedge clk);
        #1;
        rst = r; opcode = opc; funct3 = f3; zero = z; lt = l; ltu = lu; mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [21:0] act, e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {ill_act, state_o, pc_write, adr_src, mem_read, mem_write, ir_write,
                   data_en, rd_en, alu_en, reg_write, alu_src_a, alu_src_b, result_src, alu_op};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, act, e);
            end
        end
    end

    // Common hand-derived vectors
    localparam logic [21:0] ZERO_V   = 22'b0;
    localparam logic [21:0] FETCH_R  = {1'b0, 4'd0, 9'b101010000, 2'd0, 2'd2, 2'd2, 2'd0};
    localparam logic [21:0] FETCH_W  = {1'b0, 4'd0, 9'b001000000, 2'd0, 2'd2, 2'd2, 2'd0};
    localparam logic [21:0] DECODE_V = {1'b0, 4'd1, 9'b000000110, 2'd1, 2'd1, 2'd0, 2'd0};
    localparam logic [21:0] ALUWB_V  = {1'b0, 4'd8, 9'b000000001, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [21:0] MEMADR_V = {1'b0, 4'd2, 9'b000000010, 2'd2, 2'd1, 2'd0, 2'd0};

    initial begin
        logic [31:0] add_iw;
        add_iw = 32'h002081B3;

        step("rst0", 1, '0, '0, 0, 0, 0, 1, ZERO_V);
        step("rst1", 1, '0, '0, 0, 0, 0, 1, ZERO_V);

        // add x3,x1,x2
        step("add_fetch",  0, add_iw[6:0], add_iw[14:12], 0, 0, 0, 1, FETCH_R);
        step("add_decode", 0, add_iw[6:0], add_iw[14:12], 0, 0, 0, 1, DECODE_V);
        step("add_execr",  0, add_iw[6:0], add_iw[14:12], 0, 0, 0, 1,
             v(4'd6, 9'b000000010, 2'd2, 2'd0, 2'd0, 2'd2, 0));
        step("add_aluwb",  0, add_iw[6:0], add_iw[14:12], 0, 0, 0, 1, ALUWB_V);

        // lw with two wait cycles in FETCH and in MEMREAD
        step("lw_fetch_w0", 0, LOAD, 3'b010, 0, 0, 0, 0, FETCH_W);
        step("lw_fetch_w1", 0, LOAD, 3'b010, 0, 0, 0, 0, FETCH_W);
        step("lw_fetch_r",  0, LOAD, 3'b010, 0, 0, 0, 1, FETCH_R);
        step("lw_decode",   0, LOAD, 3'b010, 0, 0, 0, 0, DECODE_V);
        step("lw_memadr",   0, LOAD, 3'b010, 0, 0, 0, 0, MEMADR_V);
        step("lw_memrd_w0", 0, LOAD, 3'b010, 0, 0, 0, 0, v(4'd3, 9'b011000000, 0, 0, 0, 0, 0));
        step("lw_memrd_w1", 0, LOAD, 3'b010, 0, 0, 0, 0, v(4'd3, 9'b011000000, 0, 0, 0, 0, 0));
        step("lw_memrd_r",  0, LOAD, 3'b010, 0, 0, 0, 1, v(4'd3, 9'b011001000, 0, 0, 0, 0, 0));
        step("lw_memwb",    0, LOAD, 3'b010, 0, 0, 0, 0, v(4'd4, 9'b000000001, 0, 0, 2'd1, 0, 0));

        // branches: beq taken/not, bltu taken, bge not taken, funct3 010 never
        step("beq_t_fetch",  0, BR, 3'b000, 1, 0, 0, 1, FETCH_R);
        step("beq_t_decode", 0, BR, 3'b000, 1, 0, 0, 1, DECODE_V);
        step("beq_t_branch", 0, BR, 3'b000, 1, 0, 0, 1, v(4'd9, 9'b100000000, 2'd2, 2'd0, 2'd0, 2'd1, 0));
        step("beq_n_fetch",  0, BR, 3'b000, 0, 1, 1, 1, FETCH_R);
        step("beq_n_decode", 0, BR, 3'b000, 0, 1, 1, 1, DECODE_V);
        step("beq_n_branch", 0, BR, 3'b000, 0, 1, 1, 1, v(4'd9, 9'b000000000, 2'd2, 2'd0, 2'd0, 2'd1, 0));
        step("bltu_fetch",   0, BR, 3'b110, 0, 0, 1, 1, FETCH_R);
        step("bltu_decode",  0, BR, 3'b110, 0, 0, 1, 1, DECODE_V);
        step("bltu_branch",  0, BR, 3'b110, 0, 0, 1, 1, v(4'd9, 9'b100000000, 2'd2, 2'd0, 2'd0, 2'd1, 0));
        step("bge_fetch",    0, BR, 3'b101, 1, 1, 0, 1, FETCH_R);
        step("bge_decode",   0, BR, 3'b101, 1, 1, 0, 1, DECODE_V);
        step("bge_branch",   0, BR, 3'b101, 1, 1, 0, 1, v(4'd9, 9'b000000000, 2'd2, 2'd0, 2'd0, 2'd1, 0));
        step("f3010_fetch",  0, BR, 3'b010, 1, 1, 1, 1, FETCH_R);
        step("f3010_decode", 0, BR, 3'b010, 1, 1, 1, 1, DECODE_V);
        step("f3010_branch", 0, BR, 3'b010, 1, 1, 1, 1, v(4'd9, 9'b000000000, 2'd2, 2'd0, 2'd0, 2'd1, 0));

        // jalr x1,0(x1)
        step("jalr_fetch",  0, JALR, 3'b000, 0, 0, 0, 1, FETCH_R);
        step("jalr_decode", 0, JALR, 3'b000, 0, 0, 0, 0, DECODE_V);
        step("jalr_link",   0, JALR, 3'b000, 0, 0, 0, 0, v(4'd11, 9'b000000001, 2'd1, 2'd2, 2'd2, 2'd0, 0));
        step("jalr_jmp",    0, JALR, 3'b000, 0, 0, 0, 0, v(4'd12, 9'b100000000, 2'd2, 2'd1, 2'd2, 2'd0, 0));

        // jal
        step("jal_fetch",  0, JAL, 3'b000, 0, 0, 0, 1, FETCH_R);
        step("jal_decode", 0, JAL, 3'b000, 0, 0, 0, 1, DECODE_V);
        step("jal_jal",    0, JAL, 3'b000, 0, 0, 0, 1, v(4'd10, 9'b100000010, 2'd1, 2'd2, 2'd0, 2'd0, 0));
        step("jal_aluwb",  0, JAL, 3'b000, 0, 0, 0, 1, ALUWB_V);

        // EXECI variants
        step("lui_fetch",    0, LUI, 3'b000, 0, 0, 0, 1, FETCH_R);
        step("lui_decode",   0, LUI, 3'b000, 0, 0, 0, 1, DECODE_V);
        step("lui_execi",    0, LUI, 3'b000, 0, 0, 0, 1, v(4'd7, 9'b000000010, 2'd3, 2'd1, 2'd0, 2'd0, 0));
        step("lui_aluwb",    0, LUI, 3'b000, 0, 0, 0, 1, ALUWB_V);
        step("auipc_fetch",  0, AUIPC, 3'b000, 0, 0, 0, 1, FETCH_R);
        step("auipc_decode", 0, AUIPC, 3'b000, 0, 0, 0, 1, DECODE_V);
        step("auipc_execi",  0, AUIPC, 3'b000, 0, 0, 0, 1, v(4'd7, 9'b000000010, 2'd1, 2'd1, 2'd0, 2'd0, 0));
        step("auipc_aluwb",  0, AUIPC, 3'b000, 0, 0, 0, 1, ALUWB_V);
        step("opimm_fetch",  0, OPIMM, 3'b000, 0, 0, 0, 1, FETCH_R);
        step("opimm_decode", 0, OPIMM, 3'b000, 0, 0, 0, 1, DECODE_V);
        step("opimm_execi",  0, OPIMM, 3'b000, 0, 0, 0, 1, v(4'd7, 9'b000000010, 2'd2, 2'd1, 2'd0, 2'd2, 0));
        step("opimm_aluwb",  0, OPIMM, 3'b000, 0, 0, 0, 1, ALUWB_V);

        // sw with one wait cycle in MEMWRITE
        step("sw_fetch",    0, STORE, 3'b010, 0, 0, 0, 1, FETCH_R);
        step("sw_decode",   0, STORE, 3'b010, 0, 0, 0, 1, DECODE_V);
        step("sw_memadr",   0, STORE, 3'b010, 0, 0, 0, 1, MEMADR_V);
        step("sw_memwr_w",  0, STORE, 3'b010, 0, 0, 0, 0, v(4'd5, 9'b010100000, 0, 0, 0, 0, 0));
        step("sw_memwr_r",  0, STORE, 3'b010, 0, 0, 0, 1, v(4'd5, 9'b010100000, 0, 0, 0, 0, 0));

        // reset asserted while in MEMWRITE
        step("swr_fetch",   0, STORE, 3'b010, 0, 0, 0, 1, FETCH_R);
        step("swr_decode",  0, STORE, 3'b010, 0, 0, 0, 1, DECODE_V);
        step("swr_memadr",  0, STORE, 3'b010, 0, 0, 0, 1, MEMADR_V);
        step("swr_rst_mw",  1, STORE, 3'b010, 0, 0, 0, 1, ZERO_V);
        step("swr_rst_2",   1, STORE, 3'b010, 0, 0, 0, 1, ZERO_V);
        step("swr_fetch2",  0, STORE, 3'b010, 0, 0, 0, 0, FETCH_W);
        step("swr_fetch3",  0, STORE, 3'b010, 0, 0, 0, 1, FETCH_R);
        step("swr_decode2", 0, BAD,   3'b000, 0, 0, 0, 1, DECODE_V);

        // illegal opcode 0x7F follows the decode above
`ifdef ILLEGAL_TRAP_EN
        step("ill_trap0", 0, BAD, 3'b000, 0, 0, 0, 1, v(4'd13, 9'b0, 0, 0, 0, 0, 1));
        step("ill_trap1", 0, '0,  3'b000, 0, 0, 0, 1, v(4'd13, 9'b0, 0, 0, 0, 0, 1));
        step("ill_trap2", 0, '0,  3'b000, 0, 0, 0, 1, v(4'd13, 9'b0, 0, 0, 0, 0, 1));
        step("ill_rst",   1, '0,  3'b000, 0, 0, 0, 1, ZERO_V);
        step("ill_fetch", 0, '0,  3'b000, 0, 0, 0, 1, FETCH_R);
`else
        step("ill_fetch",  0, BAD, 3'b000, 0, 0, 0, 1, FETCH_R);
        step("ill_decode", 0, BAD, 3'b000, 0, 0, 0, 1, DECODE_V);
        step("ill_fetch2", 0, BAD, 3'b000, 0, 0, 0, 0, FETCH_W);
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
